biquad_seq_filter: RTL and testbench
====================================

Name: biquad_seq_filter

Overview:
- Second-order IIR (biquad) section for one equalizer band; consumes the registered sample produced by the pipeline-register stage.
- One shared signed multiplier, time-multiplexed over 5 products per sample.
- Output feeds the next pipeline register or band summer.
- Coefficients arrive as static ports from the band-gain control logic.

Parameters:
LARGO, 24, data/coefficient MSB index; all samples and coefficients are signed LARGO+1 bits
FRAC, 13, fractional bits of coefficients (1.0 = 2^FRAC = 8192)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
clear_i  in  1  synchronous clear of filter history (x1,x2,y1,y2)
data_i  in  LARGO+1  input sample, signed
valid_i  in  1  one-cycle strobe; data_i valid
b0_i, b1_i, b2_i  in  LARGO+1 each  feed-forward coefficients, signed QFRAC
a1_i, a2_i  in  LARGO+1 each  feedback coefficients, signed QFRAC
data_o  out  LARGO+1  filtered sample, signed, held until next result
valid_o  out  1  one-cycle pulse when data_o updates
busy_o  out  1  high while a sample is being processed
overrun_o  out  1  one-cycle pulse when valid_i arrives while busy

Behaviour:
- Transfer function: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. x1/x2 and y1/y2 are the previous two inputs and outputs.
- Reset: data_o=0, valid_o=0, busy_o=0, overrun_o=0, history=0, accumulator=0, FSM=IDLE.
- FSM states:
  - IDLE -> MAC on valid_i.
  - MAC runs idx 0..4, one product per cycle, in order b0x, b1x1, b2x2, -a1y1, -a2y2.
  - MAC -> SAT after idx 4.
  - SAT -> IDLE, writing data_o and asserting valid_o.
- Capture: at the accepting edge (cycle T), latch data_i and all five coefficients. Coefficient changes mid-sample do not affect the sample in flight.
- Latency: valid_i at edge T gives valid_o high for the cycle after edge T+7; data_o updates at that same edge. busy_o is high from T+1 through T+7 inclusive.
- Throughput: one sample per 7 clocks. Audio rate is far below this.
- valid_i while busy_o=1 is ignored (sample dropped) and overrun_o pulses for one cycle. valid_i in the same cycle that SAT completes is also ignored.
- Accumulator: signed, 2*(LARGO+1)+3 bits. Products are full-precision signed×signed, no truncation before accumulation.
- Rounding in SAT: add 2^(FRAC-1), then arithmetic shift right by FRAC. This is round-half-up, toward +inf.
- Saturation: clamp to [-2^LARGO, 2^LARGO-1]. Never wrap.
- History update at the SAT edge: x2<=x1, x1<=x, y2<=y1, y1<=saturated y.
- clear_i:
  - Zeroes history at the next edge and aborts any sample in flight (FSM->IDLE, busy_o=0, no valid_o).
  - data_o keeps its value.
  - clear_i has priority over valid_i in the same cycle.
- Reset mid-operation: everything returns immediately to reset values; no valid_o is produced for the aborted sample.

Decomposition:
- Shared package eq_pkg holds:
  - FSM state encoding (IDLE, MAC, SAT);
  - MAC_STEPS=5;
  - accumulator width function of LARGO;
  - rounding/saturation constants derived from LARGO and FRAC.
- One natural sub-module: mult_acc_signed. It provides a registered signed multiply and add/sub into the accumulator, with clear and sub controls. It is reused by the other band filters.

Test Plan:
1. Pass-through, b0=8192, others 0, x=1000 -> data_o=1000 with valid_o pulsing 7 cycles after valid_i; busy_o high for 7 cycles.
2. FIR average, b0=b1=4096, x=2000 then 0, 0 -> outputs 1000, 1000, 0.
3. Feedback and rounding, b0=8192, a1=-4096, x=1000 then zeros -> 1000, 500, 250, 125, 63, 32, 16.
4. Saturation, b0=32768 (4.0), x=8388608 -> data_o=16777215. With x=-8388608 -> data_o=-16777216.
5. Overrun, second valid_i 3 cycles after first -> overrun_o pulses once, only one valid_o, history reflects first sample only.
6. Disturbances:
   - rst asserted at MAC idx 2 -> all outputs 0 immediately, no valid_o.
   - clear_i with valid_i same cycle -> sample dropped, history zero, next x=1000 with test-3 coefficients -> 1000.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer band filters: FSM encoding, MAC step
// count and the width/rounding/saturation constants derived from LARGO and FRAC.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam int unsigned MAC_STEPS = 5;

    // Two full products plus three guard bits hold the five-term sum.
    function automatic int unsigned acc_width(input int unsigned largo);
        return 2 * (largo + 1) + 3;
    endfunction

    function automatic longint round_bias(input int unsigned frac);
        return longint'(1) << (frac - 1);
    endfunction

    function automatic longint sat_hi(input int unsigned largo);
        return (longint'(1) << largo) - 1;
    endfunction

    function automatic longint sat_lo(input int unsigned largo);
        return -(longint'(1) << largo);
    endfunction

endpackage

// File: rtl/mult_acc_signed.sv
// Registered signed multiplier feeding an add/subtract accumulator.
// The sub flag travels with its product so the sign lines up one cycle later.
module mult_acc_signed #(
    parameter int unsigned W     = 25,
    parameter int unsigned ACC_W = 53
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    mul_en,
    input  logic                    sub,
    input  logic                    acc_en,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W-1:0]   prod;
    logic                    prod_sub;
    logic signed [ACC_W-1:0] prod_ext;

    always_comb begin
        prod_ext = {{(ACC_W - 2*W){prod[2*W-1]}}, prod};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod     <= '0;
            prod_sub <= 1'b0;
            acc      <= '0;
        end else if (clr) begin
            prod     <= '0;
            prod_sub <= 1'b0;
            acc      <= '0;
        end else begin
            if (mul_en) begin
                prod     <= (2*W)'(a) * (2*W)'(b);
                prod_sub <= sub;
            end
            if (acc_en) begin
                acc <= prod_sub ? (acc - prod_ext) : (acc + prod_ext);
            end
        end
    end

endmodule

// File: rtl/biquad_seq_filter.sv
// Single-band biquad IIR section; one shared multiplier time-multiplexed over
// the five products of each sample, then round-half-up and saturate.
module biquad_seq_filter
    import eq_pkg::*;
#(
    parameter int unsigned LARGO = 24,
    parameter int unsigned FRAC  = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic signed [LARGO:0] data_i,
    input  logic               valid_i,
    input  logic signed [LARGO:0] b0_i,
    input  logic signed [LARGO:0] b1_i,
    input  logic signed [LARGO:0] b2_i,
    input  logic signed [LARGO:0] a1_i,
    input  logic signed [LARGO:0] a2_i,
    output logic signed [LARGO:0] data_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               overrun_o
);

    localparam int unsigned W     = LARGO + 1;
    localparam int unsigned ACC_W = acc_width(LARGO);
    localparam logic signed [ACC_W-1:0] BIAS   = ACC_W'(round_bias(FRAC));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(LARGO));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(LARGO));

    state_t state, state_next;
    logic [2:0] idx;
    logic       sat_phase;
    logic       accept;

    logic signed [LARGO:0] x0, x1, x2, y1, y2;
    logic signed [LARGO:0] c_b0, c_b1, c_b2, c_a1, c_a2;
    logic signed [LARGO:0] op_a, op_b;
    logic                  op_sub;
    logic                  mul_en, acc_en, acc_clr;
    logic signed [ACC_W-1:0] acc, rounded;
    logic signed [LARGO:0] ysat;

    assign accept = (state == IDLE) && valid_i && !clear_i;
    assign busy_o = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (idx == 3'(MAC_STEPS - 1)) state_next = SAT;
            SAT:     if (sat_phase) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear_i) state_next = IDLE;
    end

    always_comb begin
        op_a   = c_b0;
        op_b   = x0;
        op_sub = 1'b0;
        case (idx)
            3'd1: begin op_a = c_b1; op_b = x1; end
            3'd2: begin op_a = c_b2; op_b = x2; end
            3'd3: begin op_a = c_a1; op_b = y1; op_sub = 1'b1; end
            3'd4: begin op_a = c_a2; op_b = y2; op_sub = 1'b1; end
            default: ;
        endcase
    end

    // Product k is registered in MAC step k and summed one cycle later, so the
    // first SAT cycle absorbs the last product and the second one rounds.
    always_comb begin
        mul_en  = (state == MAC);
        acc_en  = ((state == MAC) && (idx != 3'd0)) || ((state == SAT) && !sat_phase);
        acc_clr = accept || clear_i;
    end

    mult_acc_signed #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .mul_en (mul_en),
        .sub    (op_sub),
        .acc_en (acc_en),
        .a      (op_a),
        .b      (op_b),
        .acc    (acc)
    );

    always_comb begin
        rounded = (acc + BIAS) >>> FRAC;
        if (rounded > SAT_HI)      ysat = SAT_HI[LARGO:0];
        else if (rounded < SAT_LO) ysat = SAT_LO[LARGO:0];
        else                       ysat = rounded[LARGO:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            sat_phase <= 1'b0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            c_b0      <= '0;
            c_b1      <= '0;
            c_b2      <= '0;
            c_a1      <= '0;
            c_a2      <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            overrun_o <= valid_i && (state != IDLE);
            if (clear_i) begin
                idx       <= '0;
                sat_phase <= 1'b0;
                x0        <= '0;
                x1        <= '0;
                x2        <= '0;
                y1        <= '0;
                y2        <= '0;
            end else if (accept) begin
                idx       <= '0;
                sat_phase <= 1'b0;
                x0        <= data_i;
                c_b0      <= b0_i;
                c_b1      <= b1_i;
                c_b2      <= b2_i;
                c_a1      <= a1_i;
                c_a2      <= a2_i;
            end else if (state == MAC) begin
                idx <= idx + 3'd1;
            end else if (state == SAT) begin
                if (!sat_phase) begin
                    sat_phase <= 1'b1;
                end else begin
                    sat_phase <= 1'b0;
                    data_o    <= ysat;
                    valid_o   <= 1'b1;
                    x2        <= x1;
                    x1        <= x0;
                    y2        <= y1;
                    y1        <= ysat;
                end
            end
        end
    end

endmodule

// File: tb/tb_biquad_seq_filter.sv
// Self-checking bench: directed literal cases plus randomized traffic against a
// sample-level behavioural model of the biquad.
module tb_biquad_seq_filter;

    localparam int unsigned LARGO = 24;
    localparam int unsigned FRAC  = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_i = 1'b0;
    logic valid_i = 1'b0;
    logic signed [LARGO:0] data_i = '0;
    logic signed [LARGO:0] b0_i = '0, b1_i = '0, b2_i = '0, a1_i = '0, a2_i = '0;
    logic signed [LARGO:0] data_o;
    logic valid_o, busy_o, overrun_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    biquad_seq_filter #(.LARGO(LARGO), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .b0_i      (b0_i),
        .b1_i      (b1_i),
        .b2_i      (b2_i),
        .a1_i      (a1_i),
        .a2_i      (a2_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model (sample level) ----------------
    longint hx1 = 0, hx2 = 0, hy1 = 0, hy2 = 0;
    longint x_pend = 0, y_pend = 0;
    longint m_data = 0;
    bit     m_valid = 0, m_busy = 0, m_ovr = 0, pending = 0;
    longint cyc = 0, done_at = 0;

    function automatic longint biquad(input longint x, input longint b0, input longint b1,
                                      input longint b2, input longint a1, input longint a2);
        longint s, r;
        s = b0 * x + b1 * hx1 + b2 * hx2 - a1 * hy1 - a2 * hy2;
        r = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > (longint'(1) <<< LARGO) - 1) r = (longint'(1) <<< LARGO) - 1;
        if (r < -(longint'(1) <<< LARGO))    r = -(longint'(1) <<< LARGO);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 0; m_valid = 0; m_busy = 0; m_ovr = 0; m_data = 0;
            hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
        end else begin
            cyc     = cyc + 1;
            m_ovr   = valid_i && pending;
            m_valid = 0;
            if (clear_i) begin
                pending = 0;
                hx1 = 0; hx2 = 0; hy1 = 0; hy2 = 0;
            end else if (pending && cyc == done_at) begin
                m_data  = y_pend;
                m_valid = 1;
                hx2 = hx1; hx1 = x_pend; hy2 = hy1; hy1 = y_pend;
                pending = 0;
            end else if (!pending && valid_i) begin
                x_pend  = longint'(data_i);
                y_pend  = biquad(longint'(data_i), longint'(b0_i), longint'(b1_i),
                                 longint'(b2_i), longint'(a1_i), longint'(a2_i));
                pending = 1;
                done_at = cyc + 7;
            end
            m_busy = pending;
        end
    end

    always @(negedge clk) begin
        check("valid_o",   longint'(valid_o),   longint'(m_valid));
        check("busy_o",    longint'(busy_o),    longint'(m_busy));
        check("overrun_o", longint'(overrun_o), longint'(m_ovr));
        check("data_o",    longint'(data_o),    m_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        b0_i = 25'(b0); b1_i = 25'(b1); b2_i = 25'(b2); a1_i = 25'(a1); a2_i = 25'(a2);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic send_expect(input string name, input int x, input longint exp,
                               output int lat, output int busy_cnt);
        bit got;
        data_i  = 25'(x);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        lat = 0; busy_cnt = 0; got = 0;
        while (!got && lat < 20) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
            if (valid_o) got = 1;
        end
        if (got) begin
            check(name, longint'(data_o), exp);
            check({"model ", name}, m_data, exp);
        end else begin
            checks++;
            $display("FAIL %s timeout: no valid_o within %0d cycles, expected data %0d", name, lat, exp);
        end
    endtask

    function automatic int rnd_coef();
        if ($urandom_range(3) == 0) return int'($signed(25'($urandom)));
        return int'($urandom_range(32768)) - 16384;
    endfunction

    function automatic int rnd_data();
        if ($urandom_range(7) == 0) return int'($signed(25'($urandom)));
        return int'($urandom_range(200000)) - 100000;
    endfunction

    // ---------------- main sequence ----------------
    int lat, bc, ovr_cnt, val_cnt;
    longint cap;
    int seq3 [7] = '{1000, 500, 250, 125, 63, 32, 16};

    initial begin
        #1;
        check("reset data_o",    longint'(data_o),    0);
        check("reset valid_o",   longint'(valid_o),   0);
        check("reset busy_o",    longint'(busy_o),    0);
        check("reset overrun_o", longint'(overrun_o), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // pass-through with latency and busy duration
        set_coefs(8192, 0, 0, 0, 0);
        send_expect("passthru", 1000, 1000, lat, bc);
        check("passthru latency", lat, 7);
        check("passthru busy cycles", bc, 7);

        // two-tap average
        do_clear();
        set_coefs(4096, 4096, 0, 0, 0);
        send_expect("fir0", 2000, 1000, lat, bc);
        send_expect("fir1", 0, 1000, lat, bc);
        send_expect("fir2", 0, 0, lat, bc);

        // feedback decay with round-half-up
        do_clear();
        set_coefs(8192, 0, 0, -4096, 0);
        for (int unsigned i = 0; i < 7; i++)
            send_expect($sformatf("iir%0d", i), (i == 0) ? 1000 : 0, seq3[i], lat, bc);

        // saturation both directions
        do_clear();
        set_coefs(32768, 0, 0, 0, 0);
        send_expect("sat_pos", 8388608, 16777215, lat, bc);
        send_expect("sat_neg", -8388608, -16777216, lat, bc);

        // overrun: second strobe three cycles after the first is dropped
        do_clear();
        set_coefs(8192, 0, 0, -4096, 0);
        data_i = 25'(1000); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        data_i = 25'(5000); valid_i = 1'b1;
        ovr_cnt = 0; val_cnt = 0; cap = 0;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            valid_i = 1'b0;
            if (overrun_o) ovr_cnt++;
            if (valid_o) begin val_cnt++; cap = longint'(data_o); end
        end
        check("overrun pulses", ovr_cnt, 1);
        check("overrun valid count", val_cnt, 1);
        check("overrun data", cap, 1000);
        send_expect("overrun history", 0, 500, lat, bc);

        // async reset in the middle of MAC
        set_coefs(8192, 0, 0, 0, 0);
        data_i = 25'(1234); valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("midrst data_o",    longint'(data_o),    0);
        check("midrst valid_o",   longint'(valid_o),   0);
        check("midrst busy_o",    longint'(busy_o),    0);
        check("midrst overrun_o", longint'(overrun_o), 0);
        tick(); tick();
        rst = 1'b0;
        val_cnt = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            if (valid_o) val_cnt++;
        end
        check("midrst no valid", val_cnt, 0);

        // clear wins over a same-cycle strobe
        set_coefs(8192, 0, 0, -4096, 0);
        send_expect("pre clear", 3000, 3000, lat, bc);
        clear_i = 1'b1; valid_i = 1'b1; data_i = 25'(7777);
        tick();
        clear_i = 1'b0; valid_i = 1'b0;
        val_cnt = 0;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            if (valid_o) val_cnt++;
        end
        check("clear drop no valid", val_cnt, 0);
        send_expect("after clear", 1000, 1000, lat, bc);
        send_expect("after clear decay", 0, 500, lat, bc);

        // random traffic; coefficients wander every few cycles, including mid-sample
        set_coefs(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
        for (int unsigned i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(5) == 0);
            data_i  = 25'(rnd_data());
            clear_i = ($urandom_range(80) == 0);
            if ($urandom_range(3) == 0)
                set_coefs(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
            if ($urandom_range(400) == 0) begin
                set_coefs(8192, 0, 0, -4096, 0);
            end
            tick();
        end
        valid_i = 1'b0;
        clear_i = 1'b0;
        for (int unsigned i = 0; i < 12; i++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
